// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_pkg
//  Brief    : Shared constants, controller state type, 7-segment decoder and
//             single-digit BCD increment/decrement helpers for the stopwatch.
//  Revision : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    // All segments and the decimal point off (active-low)
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [0:0] {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } sw_state_t;

    // Active-low {g,f,e,d,c,b,a}; any non-decimal code blanks the digit
    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Digit increment; 9 rolls to 0 (the caller derives the carry)
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Digit decrement; 0 rolls to 9 (the caller derives the borrow)
    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return ((d == 4'd0) || (d > 4'd9)) ? 4'd9 : d - 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_mux
//  Brief    : Multiplexed 7-segment scanner: scan prescaler, digit index,
//             registered anode/segment drive and display-enable blanking.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_mux #(
    parameter int DIGITS = 4,
    parameter int SDIV   = 2,
    parameter int DP_POS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dispen,
    input  logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg
);
    import stopwatch_pkg::*;

    localparam int SW = (SDIV > 1) ? $clog2(SDIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SW-1:0] c_sdiv_max = SW'(SDIV - 1);
    localparam logic [IW-1:0] c_idx_max  = IW'(DIGITS - 1);

    logic [SW-1:0]      r_sdiv;
    logic [IW-1:0]      r_idx;
    logic [3:0]         w_digit;
    logic [DIGITS-1:0]  w_an;
    logic               w_dp;

    // Scan prescaler and digit index: index steps once every SDIV cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sdiv <= '0;
            r_idx  <= '0;
        end else if (r_sdiv == c_sdiv_max) begin
            r_sdiv <= '0;
            r_idx  <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
        end else begin
            r_sdiv <= r_sdiv + 1'b1;
        end
    end

    // Select the digit under the current index and build its anode pattern
    always_comb begin
        w_digit = 4'd0;
        w_an    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(r_idx) == i) begin
                w_digit = digits[4*i +: 4];
                w_an[i] = 1'b0;
            end
        end
        w_dp = (int'(r_idx) != DP_POS);
    end

    // Registered pin drive; blanking only gates the pins, scanning keeps going
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else if (dispen) begin
            an  <= w_an;
            seg <= {w_dp, seg7_decode(w_digit)};
        end else begin
            an  <= '1;
            seg <= SEG_BLANK;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_ndigit.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ndigit
//  Brief    : N-digit BCD stopwatch / countdown timer with button edge
//             detection, preset load, lap freeze, wrap/done flags and a
//             multiplexed 7-segment display driver.
//  Revision : 1.0  initial release
// ============================================================================
module stopwatch_ndigit #(
    parameter int DIGITS  = 4,
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100,
    parameter int SCAN_HZ = 1000,
    parameter int DP_POS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  inc,
    input  logic                  lap,
    input  logic                  load,
    input  logic                  up_down,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  dispen,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  wrap,
    output logic                  done
);
    import stopwatch_pkg::*;

    localparam int W    = 4 * DIGITS;
    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int SDIV = CLK_HZ / SCAN_HZ;
    localparam int PW   = $clog2(DIV);
    localparam logic [PW-1:0] c_div_max = PW'(DIV - 1);

    logic            r_start_q, r_stop_q, r_inc_q, r_lap_q, r_load_q, r_up_down_q;
    logic            w_start_e, w_stop_e, w_inc_e, w_lap_e, w_load_e;
    sw_state_t       r_state;
    logic [PW-1:0]   r_presc;
    logic            w_tick;
    logic [W-1:0]    r_count, r_lap_val, w_display;
    logic [W-1:0]    w_inc_val, w_dec_val, w_preset_bcd;
    logic            w_all9, w_zero, w_dec_zero;
    logic            r_lap_hold, r_wrap, r_done;

    // Previous-cycle copies of the button and mode inputs for edge/change detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start_q   <= 1'b0;
            r_stop_q    <= 1'b0;
            r_inc_q     <= 1'b0;
            r_lap_q     <= 1'b0;
            r_load_q    <= 1'b0;
            r_up_down_q <= 1'b0;
        end else begin
            r_start_q   <= start;
            r_stop_q    <= stop;
            r_inc_q     <= inc;
            r_lap_q     <= lap;
            r_load_q    <= load;
            r_up_down_q <= up_down;
        end
    end

    assign w_start_e = start & ~r_start_q;
    assign w_stop_e  = stop  & ~r_stop_q;
    assign w_inc_e   = inc   & ~r_inc_q;
    assign w_lap_e   = lap   & ~r_lap_q;
    assign w_load_e  = load  & ~r_load_q;
    assign w_tick    = (r_state == RUNNING) && (r_presc == c_div_max);

    // Whole-word ripple +1/-1 candidates, all-9s/all-0s flags and preset cleanup
    always_comb begin
        logic       w_carry;
        logic       w_borrow;
        logic [3:0] w_dig;
        logic [3:0] w_pre;
        w_carry      = 1'b1;
        w_borrow     = 1'b1;
        w_inc_val    = '0;
        w_dec_val    = '0;
        w_preset_bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_dig = r_count[4*i +: 4];
            w_pre = preset[4*i +: 4];
            w_inc_val[4*i +: 4]    = w_carry  ? bcd_inc(w_dig) : w_dig;
            w_dec_val[4*i +: 4]    = w_borrow ? bcd_dec(w_dig) : w_dig;
            w_preset_bcd[4*i +: 4] = (w_pre > 4'd9) ? 4'd0 : w_pre;
            w_carry  = w_carry  & (w_dig == 4'd9);
            w_borrow = w_borrow & (w_dig == 4'd0);
        end
        w_all9     = w_carry;
        w_zero     = w_borrow;
        w_dec_zero = (w_dec_val == '0);
    end

    // Control FSM, tick prescaler and BCD counter; priority load > stop > start > inc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= STOPPED;
            r_presc <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            // A mode flip invalidates a finished countdown; a new done below wins
            if (up_down != r_up_down_q) begin
                r_done <= 1'b0;
            end
            if (w_load_e) begin
                r_count <= w_preset_bcd;
                r_state <= STOPPED;
                r_done  <= 1'b0;
                r_presc <= '0;
            end else if (w_stop_e) begin
                r_state <= STOPPED;
            end else if (w_start_e) begin
                r_done  <= 1'b0;
                r_presc <= '0;
                // A countdown from zero has nothing to do
                if (!(up_down && w_zero)) begin
                    r_state <= RUNNING;
                end
            end else if (w_inc_e && (r_state == STOPPED)) begin
                if (!up_down) begin
                    r_count <= w_inc_val;
                    r_wrap  <= w_all9;
                end else if (!w_zero) begin
                    r_count <= w_dec_val;
                end
            end else if (r_state == RUNNING) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                if (w_tick) begin
                    if (!up_down) begin
                        r_count <= w_inc_val;
                        r_wrap  <= w_all9;
                    end else if (w_zero) begin
                        // Mode switched to down while sitting at zero
                        r_state <= STOPPED;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= w_dec_val;
                        if (w_dec_zero) begin
                            r_state <= STOPPED;
                            r_done  <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Lap register: first edge freezes a snapshot, second edge returns to live
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap_hold <= 1'b0;
            r_lap_val  <= '0;
        end else if (w_load_e) begin
            r_lap_hold <= 1'b0;
        end else if (w_lap_e) begin
            if (!r_lap_hold) begin
                r_lap_val  <= r_count;
                r_lap_hold <= 1'b1;
            end else begin
                r_lap_hold <= 1'b0;
            end
        end
    end

    assign w_display = r_lap_hold ? r_lap_val : r_count;

    seg_scan_mux #(
        .DIGITS (DIGITS),
        .SDIV   (SDIV),
        .DP_POS (DP_POS)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .dispen (dispen),
        .digits (w_display),
        .an     (an),
        .seg    (seg)
    );

    assign count   = r_count;
    assign running = (r_state == RUNNING);
    assign wrap    = r_wrap;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ndigit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_ndigit
//  Brief    : Directed self-checking bench for stopwatch_ndigit
//             (4 digits, DIV = 10, SDIV = 2, decimal point on index 2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stopwatch_ndigit;

    localparam int P_START = 0;
    localparam int P_STOP  = 1;
    localparam int P_INC   = 2;
    localparam int P_LAP   = 3;
    localparam int P_LOAD  = 4;

    logic        clk = 1'b0;
    logic        rst, start, stop, inc, lap, load, up_down, dispen;
    logic [15:0] preset;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] count;
    logic        running, wrap, done;

    int n_checks = 0;
    int n_pass   = 0;

    stopwatch_ndigit #(
        .DIGITS  (4),
        .CLK_HZ  (100),
        .TICK_HZ (10),
        .SCAN_HZ (50),
        .DP_POS  (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .inc     (inc),
        .lap     (lap),
        .load    (load),
        .up_down (up_down),
        .preset  (preset),
        .dispen  (dispen),
        .an      (an),
        .seg     (seg),
        .count   (count),
        .running (running),
        .wrap    (wrap),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n clocks and land 1 time unit after the last rising edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle button press; its action is visible when this returns
    task automatic pulse(input int which);
        case (which)
            P_START: start = 1'b1;
            P_STOP:  stop  = 1'b1;
            P_INC:   inc   = 1'b1;
            P_LAP:   lap   = 1'b1;
            default: load  = 1'b1;
        endcase
        cyc(1);
        start = 1'b0; stop = 1'b0; inc = 1'b0; lap = 1'b0; load = 1'b0;
    endtask

    // Wait (bounded) for the cycle in which an first switches to tgt
    task automatic wait_an(input logic [3:0] tgt, input string tag);
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            prev = an;
            cyc(1);
            if (an == tgt && prev != tgt) found = 1'b1;
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; inc = 1'b0; lap = 1'b0;
        load = 1'b0; up_down = 1'b0; dispen = 1'b1; preset = 16'h0000;
        cyc(3);
        chk("rst_count",   count,   16'h0000);
        chk("rst_running", running, 1'b0);
        chk("rst_an",      an,      4'hF);
        chk("rst_seg",     seg,     8'hFF);
        chk("rst_flags",   {wrap, done}, 2'b00);
        rst = 1'b0;
        cyc(2);

        // 1. Free run from reset, first tick exactly DIV cycles after start
        pulse(P_START);
        chk("t1_running", running, 1'b1);
        cyc(9);
        chk("t1_before_first_tick", count, 16'h0000);
        cyc(1);
        chk("t1_first_tick", count, 16'h0001);
        cyc(90);
        chk("t1_count_100", count, 16'h0010);
        chk("t1_running_100", running, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_count",   count,   16'h0000);
        chk("t1_async_running", running, 1'b0);
        chk("t1_async_an",      an,      4'hF);
        chk("t1_async_seg",     seg,     8'hFF);
        cyc(1);
        rst = 1'b0;
        cyc(1);

        // 2. Up-count wrap from 9999
        preset = 16'h9999;
        pulse(P_LOAD);
        chk("t2_load", count, 16'h9999);
        pulse(P_START);
        cyc(9);
        chk("t2_pre_wrap", {wrap, count}, {1'b0, 16'h9999});
        cyc(1);
        chk("t2_wrap_count", count, 16'h0000);
        chk("t2_wrap_pulse", wrap, 1'b1);
        chk("t2_running", running, 1'b1);
        cyc(1);
        chk("t2_wrap_gone", wrap, 1'b0);
        pulse(P_STOP);

        // 3. Countdown to zero, done sticky, start at zero ignored
        up_down = 1'b1;
        preset  = 16'h0003;
        pulse(P_LOAD);
        pulse(P_START);
        cyc(29);
        chk("t3_count_29", count, 16'h0001);
        chk("t3_running_29", running, 1'b1);
        cyc(1);
        chk("t3_zero", count, 16'h0000);
        chk("t3_stopped", running, 1'b0);
        chk("t3_done", done, 1'b1);
        cyc(20);
        chk("t3_hold", {running, done, count}, {1'b0, 1'b1, 16'h0000});
        pulse(P_INC);
        chk("t3_dec_inc_at_zero", count, 16'h0000);
        up_down = 1'b0;
        cyc(1);
        chk("t3_done_mode_clear", done, 1'b0);
        up_down = 1'b1;
        cyc(1);
        pulse(P_START);
        chk("t3_start_zero_ignored", running, 1'b0);

        // 4. start+stop together, inc while stopped/running, inc wrap
        up_down = 1'b0;
        preset  = 16'h0042;
        pulse(P_LOAD);
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        chk("t4_start_stop", running, 1'b0);
        chk("t4_count", count, 16'h0042);
        pulse(P_INC);
        chk("t4_inc", count, 16'h0043);
        pulse(P_START);
        pulse(P_INC);
        chk("t4_inc_running", count, 16'h0043);
        pulse(P_STOP);
        chk("t4_stop", running, 1'b0);
        preset = 16'h9999;
        pulse(P_LOAD);
        pulse(P_INC);
        chk("t4_inc_wrap_count", count, 16'h0000);
        chk("t4_inc_wrap_pulse", wrap, 1'b1);
        cyc(1);
        chk("t4_inc_wrap_gone", wrap, 1'b0);

        // 5. Lap freeze while the counter keeps going
        preset = 16'h0005;
        pulse(P_LOAD);
        pulse(P_START);
        pulse(P_LAP);
        cyc(32);
        chk("t5_count_live", count, 16'h0008);
        pulse(P_STOP);
        wait_an(4'b1110, "t5_scan_found");
        chk("t5_frozen_digit0", seg, 8'h92);
        chk("t5_count_after", count, 16'h0008);
        pulse(P_LAP);
        wait_an(4'b1110, "t5_scan_found2");
        chk("t5_live_digit0", seg, 8'h80);

        // 6. Scan sequence for 1234, dp on index 2, then blanking
        preset = 16'h1234;
        pulse(P_LOAD);
        wait_an(4'b1110, "t6_scan_found");
        chk("t6_seg0", seg, 8'h99);
        cyc(2);
        chk("t6_an1", an, 4'b1101);
        chk("t6_seg1", seg, 8'hB0);
        cyc(2);
        chk("t6_an2", an, 4'b1011);
        chk("t6_seg2_dp", seg, 8'h24);
        cyc(2);
        chk("t6_an3", an, 4'b0111);
        chk("t6_seg3", seg, 8'hF9);
        cyc(2);
        chk("t6_an_back0", an, 4'b1110);
        dispen = 1'b0;
        cyc(1);
        chk("t6_blank_an", an, 4'hF);
        chk("t6_blank_seg", seg, 8'hFF);
        chk("t6_count_kept", count, 16'h1234);
        dispen = 1'b1;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
